// File: rtl/gmii_router_definitions.sv
// Shared router types and constants used by the MAC table writer and the
// destination lookup engine.
package gmii_router_definitions;

  localparam int PORT_NUMBER    = 4;
  localparam int MAC_TABLE_SIZE = 4;
  localparam int PORT_IDX_W     = (PORT_NUMBER > 1) ? $clog2(PORT_NUMBER) : 1;

  localparam logic [47:0] BROADCAST = 48'hFFFF_FFFF_FFFF;

  typedef logic [47:0]            mac_addr_t;
  typedef logic [PORT_NUMBER-1:0] port_mask_t;

  // Empty table slots hold BROADCAST, so they never produce a hit.
  typedef struct packed {
    mac_addr_t [PORT_NUMBER-1:0][MAC_TABLE_SIZE-1:0] main_switch_table;
  } switch_table;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } lookup_state_t;

  function automatic logic is_group_mac(input logic [47:0] mac);
    return mac[40];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 upward,
// wrapping modulo WIDTH, and reports the first requester found.
module rr_arbiter #(
  parameter int WIDTH = 4,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             grant_valid_o
);

  logic [IDX_W-1:0] idx;

  // Walk offsets from farthest to nearest so the closest requester wins.
  always_comb begin
    grant_o       = last_grant_i;
    grant_valid_o = 1'b0;
    idx           = '0;
    for (int off = WIDTH; off >= 1; off--) begin
      idx = IDX_W'((int'(last_grant_i) + off) % WIDTH);
      if (req_i[idx]) begin
        grant_o       = idx;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dst_mac_lookup.sv
// Destination MAC lookup: arbitrates port requests, scans the live MAC table
// one port per cycle and returns an egress mask plus flood flag.
module dst_mac_lookup
  import gmii_router_definitions::*;
#(
  parameter bit SELF_FILTER = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  switch_table                  mac_table,
  input  logic [PORT_NUMBER-1:0]       lkp_req_valid,
  output logic [PORT_NUMBER-1:0]       lkp_req_ready,
  input  logic [PORT_NUMBER-1:0][47:0] lkp_dst_mac,
  output logic [PORT_NUMBER-1:0]       lkp_rsp_valid,
  output logic [PORT_NUMBER-1:0]       lkp_rsp_mask,
  output logic                         lkp_rsp_flood
);

  lookup_state_t           state_q, state_d;
  logic [PORT_IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [PORT_IDX_W-1:0]   src_port_q, src_port_d;
  logic [PORT_IDX_W-1:0]   scan_idx_q, scan_idx_d;
  mac_addr_t               dst_mac_q, dst_mac_d;
  port_mask_t              hit_mask_q, hit_mask_d;
  port_mask_t              rsp_valid_q, rsp_valid_d;
  port_mask_t              rsp_mask_q, rsp_mask_d;
  logic                    rsp_flood_q, rsp_flood_d;

  logic [PORT_IDX_W-1:0]   grant;
  logic                    grant_valid;
  logic                    port_hit;
  mac_addr_t               entry;

  rr_arbiter #(
    .WIDTH (PORT_NUMBER)
  ) u_arbiter (
    .req_i         (lkp_req_valid),
    .last_grant_i  (last_grant_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  // All entries of the port under scan are compared in parallel.
  always_comb begin
    port_hit = 1'b0;
    entry    = '0;
    for (int e = 0; e < MAC_TABLE_SIZE; e++) begin
      entry = mac_table.main_switch_table[scan_idx_q][e];
      if ((entry == dst_mac_q) && (entry != BROADCAST)) begin
        port_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    src_port_d    = src_port_q;
    scan_idx_d    = scan_idx_q;
    dst_mac_d     = dst_mac_q;
    hit_mask_d    = hit_mask_q;
    rsp_valid_d   = '0;
    rsp_mask_d    = rsp_mask_q;
    rsp_flood_d   = rsp_flood_q;
    lkp_req_ready = '0;

    unique case (state_q)
      IDLE: begin
        if (rst_n && grant_valid) begin
          lkp_req_ready[grant] = 1'b1;
          dst_mac_d            = lkp_dst_mac[grant];
          src_port_d           = grant;
          last_grant_d         = grant;
          hit_mask_d           = '0;
          scan_idx_d           = '0;
          state_d              = SCAN;
        end
      end

      SCAN: begin
        hit_mask_d[scan_idx_q] = hit_mask_q[scan_idx_q] | port_hit;
        scan_idx_d             = scan_idx_q + 1'b1;
        // The result is registered on the last scan edge so it lines up with RESP.
        if (scan_idx_q == PORT_IDX_W'(PORT_NUMBER - 1)) begin
          state_d                 = RESP;
          rsp_valid_d[src_port_q] = 1'b1;
          if (is_group_mac(dst_mac_q) || (hit_mask_d == '0)) begin
            rsp_mask_d  = '1;
            rsp_flood_d = 1'b1;
          end else begin
            rsp_mask_d  = hit_mask_d;
            rsp_flood_d = 1'b0;
          end
          if (SELF_FILTER) begin
            rsp_mask_d[src_port_q] = 1'b0;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_IDX_W'(PORT_NUMBER - 1);
      src_port_q   <= '0;
      scan_idx_q   <= '0;
      dst_mac_q    <= '0;
      hit_mask_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_mask_q   <= '0;
      rsp_flood_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      src_port_q   <= src_port_d;
      scan_idx_q   <= scan_idx_d;
      dst_mac_q    <= dst_mac_d;
      hit_mask_q   <= hit_mask_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_mask_q   <= rsp_mask_d;
      rsp_flood_q  <= rsp_flood_d;
    end
  end

  assign lkp_rsp_valid = rsp_valid_q;
  assign lkp_rsp_mask  = rsp_mask_q;
  assign lkp_rsp_flood = rsp_flood_q;

endmodule

// File: doc/dst_mac_lookup.md
# dst_mac_lookup

Destination lookup engine that sits directly downstream of the MAC table writer. It consumes the registered `switch_table` and answers per-port queries of the form "which egress ports should carry a frame with this destination MAC". Ingress ports raise a request carrying the destination MAC. The block arbitrates round-robin, scans the table one port per cycle, and returns a one-hot-addressed egress port mask plus a flood flag.

## Interface

**Parameters**
- `SELF_FILTER`, default 1: when 1, the requesting port's bit is always cleared from the result mask.
- `PORT_NUMBER`, `MAC_TABLE_SIZE` and `BROADCAST` come from `gmii_router_definitions`. They are not module parameters.

**Ports** (all signals are synchronous to `clk`)
- `clk` in 1: single clock for the block.
- `rst_n` in 1: reset, synchronous, active-low.
- `mac_table` in `switch_table`: live table from the MAC table writer.
- `lkp_req_valid` in `[PORT_NUMBER]`: per-port request.
- `lkp_req_ready` out `[PORT_NUMBER]`: per-port accept. At most one bit is high.
- `lkp_dst_mac` in `[PORT_NUMBER][48]`: per-port destination MAC. The requester holds it stable while valid and not yet accepted.
- `lkp_rsp_valid` out `[PORT_NUMBER]`: one-cycle pulse, one-hot, addressed to the requester.
- `lkp_rsp_mask` out `PORT_NUMBER`: egress mask, shared by all ports. Valid only while any `lkp_rsp_valid` bit is high.
- `lkp_rsp_flood` out 1: high when the result is a flood. Shared; qualified the same way as `lkp_rsp_mask`.

## Operation

**FSM states:** IDLE, SCAN, RESP.

**IDLE**
- The grant is computed combinationally by round-robin over `lkp_req_valid`.
- The search starts at `last_grant+1` and wraps modulo `PORT_NUMBER`.
- `lkp_req_ready[g]` = (state==IDLE) && valid[g] && g==grant.
- On accept:
  - latch `dst_mac` and `src_port` = g;
  - set `last_grant` = g;
  - clear `hit_mask`;
  - set `scan_idx` = 0;
  - go to SCAN.

**SCAN**
- Each cycle, port `scan_idx` is compared: all `MAC_TABLE_SIZE` entries of `mac_table.main_switch_table[scan_idx]` are compared in parallel against `dst_mac`.
- `hit_mask[scan_idx]` is set if any entry equals `dst_mac` and that entry != `BROADCAST`. Empty slots never match.
- `scan_idx` increments each cycle.
- After `scan_idx == PORT_NUMBER-1`, go to RESP.

**RESP**
- Drive `lkp_rsp_valid[src_port]` = 1 for exactly one cycle, then return to IDLE.
- Result rules:
  - **Group address** (`dst_mac[40]`==1; this includes `BROADCAST`): mask = all ones, flood = 1. The table is still scanned but the result ignores it.
  - **Unicast with no hit:** mask = all ones, flood = 1.
  - **Unicast with a hit:** mask = `hit_mask`, flood = 0. If several ports hit (station moved, not yet aged), all of them are set.
  - **SELF_FILTER = 1:** the `src_port` bit is cleared after the rules above. A hit only on the source port therefore gives mask = 0, flood = 0 (drop).

**Boundary conditions**
- The table is read live. Each port's contribution reflects the table value in that port's scan cycle. No snapshot is taken.
- Requests arriving during SCAN or RESP wait. Their `ready` stays low and no request is lost.
- If `rst_n` goes low mid-scan, the lookup is aborted. No response is issued, and the next cycle starts in IDLE.

## Timing

**Reset values** (applied while `rst_n`=0 on a rising edge):
- state = IDLE;
- `last_grant` = `PORT_NUMBER-1`, so port 0 has first priority;
- `lkp_rsp_valid` = 0, `lkp_rsp_mask` = 0, `lkp_rsp_flood` = 0;
- `lkp_req_ready` = 0 while in reset.

**Latency**
- Accept occurs at edge T. Scan cycles are T+1 … T+`PORT_NUMBER`.
- `lkp_rsp_valid` is high during cycle T+`PORT_NUMBER`+1.

**Throughput**
- The next accept can occur at the edge ending the RESP cycle.
- This gives one lookup per `PORT_NUMBER`+2 cycles.

**Output registering**
- `lkp_rsp_mask` and `lkp_rsp_flood` are registered and hold their value until the next RESP.
- `lkp_rsp_valid` is registered.
- `lkp_req_ready` is combinational from state, valid and `last_grant`.

## Structure

**Add to `gmii_router_definitions`:**
- `typedef logic [PORT_NUMBER-1:0] port_mask_t`;
- enum `lookup_state_t` {IDLE, SCAN, RESP};
- function `is_group_mac(logic [47:0])`, which returns bit 40.

**Sub-module:** `rr_arbiter`, parameterised by width.
- Inputs: `req` vector and `last_grant` index.
- Outputs: `grant` index and `grant_valid`.
- Purely combinational.
- The `last_grant` register and the FSM live in `dst_mac_lookup`.

## Test plan

Bench configuration: `PORT_NUMBER`=4, `MAC_TABLE_SIZE`=4.

1. **Reset and first priority.** Hold reset for 3 cycles, then release with all table entries = `BROADCAST`. Request from port 0 with `dst_mac`=48'h5A0101010101.
   - Required: ready[0] in the first IDLE cycle; rsp_valid[0] 5 cycles after accept; mask=4'b1110; flood=1.
2. **Unicast hit.** Table port 2 entry 0 = 48'h5A0101010101. Request from port 1 with that MAC.
   - Required: mask=4'b0100, flood=0.
   - Repeat from port 2: mask=4'b0000, flood=0.
3. **Broadcast and multicast.**
   - Request from port 3 with dst=48'hFFFFFFFFFFFF: mask=4'b0111, flood=1.
   - Request with dst=48'h01005E000001 while that MAC sits in the table on port 0: still mask=4'b0111, flood=1.
4. **Round-robin fairness.** All 4 valids held high continuously.
   - Required accept order: 0, 1, 2, 3, 0.
   - Accepts are spaced exactly 6 cycles apart; `lkp_req_ready` is never high on two bits at once.
5. **Multi-port hit and reset abort.**
   - MAC present on ports 0 and 3; request from port 1 → mask=4'b1001.
   - Separately, pull `rst_n` low 2 cycles after an accept → no `rsp_valid` pulse; port 0 is granted first after release.
